fll_accum_index: RTL and testbench

Upstream stage of the FLL discriminator truncation path. It accumulates signed frequency-error samples over a fixed dump interval. At each dump it serially scans the accumulated total for its most-significant magnitude bit. It then presents the 19-bit total plus a 5-bit index, which the downstream truncation stage uses to select a 15-bit normalized window.

---
 rtl/fll_accum_index.sv | 135 +++++++++++++
 tb/tb_fll_accum_index.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fll_accum_index.sv
// FLL discriminator accumulate-and-index stage.
// Sums signed error samples over a fixed dump interval with saturation, then
// serially scans the dumped total from the top magnitude bit downwards to find
// the highest bit that differs from the sign bit. The total and that bit index
// are presented together so the truncation stage can pick its window.
module fll_accum_index #(
  parameter int IN_WIDTH    = 16,
  parameter int ACC_WIDTH   = 19,
  parameter int INDEX_WIDTH = 5,
  parameter int DUMP_COUNT  = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [IN_WIDTH-1:0]    in_sample,
  output logic                   out_valid,
  output logic [ACC_WIDTH-1:0]   out_value,
  output logic [INDEX_WIDTH-1:0] out_index,
  output logic                   overrun
);

  localparam int CNT_W = (DUMP_COUNT > 1) ? $clog2(DUMP_COUNT) : 1;
  localparam logic [CNT_W-1:0]       CNT_LAST = CNT_W'(DUMP_COUNT - 1);
  localparam logic [CNT_W-1:0]       CNT_ONE  = CNT_W'(1);
  localparam logic [ACC_WIDTH-1:0]   ACC_MAX  = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0]   ACC_MIN  = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  localparam logic [INDEX_WIDTH-1:0] POS_TOP  = INDEX_WIDTH'(ACC_WIDTH - 2);
  localparam logic [INDEX_WIDTH-1:0] POS_ONE  = INDEX_WIDTH'(1);
  localparam logic [INDEX_WIDTH-1:0] POS_ZERO = INDEX_WIDTH'(0);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t                 state_r;
  logic [ACC_WIDTH-1:0]   acc_r;
  logic [CNT_W-1:0]       cnt_r;
  logic [ACC_WIDTH-1:0]   scan_r;
  logic [INDEX_WIDTH-1:0] pos_r;
  logic                   out_valid_r;
  logic [ACC_WIDTH-1:0]   out_value_r;
  logic [INDEX_WIDTH-1:0] out_index_r;
  logic                   overrun_r;

  logic [ACC_WIDTH:0]     sample_ext_s;
  logic [ACC_WIDTH:0]     sum_s;
  logic [ACC_WIDTH-1:0]   sat_s;
  logic                   dump_s;
  logic                   scan_bit_s;

  // Saturating next accumulator value, dump detection and current scan bit.
  always_comb begin
    sample_ext_s = {{(ACC_WIDTH + 1 - IN_WIDTH){in_sample[IN_WIDTH-1]}}, in_sample};
    sum_s        = {acc_r[ACC_WIDTH-1], acc_r} + sample_ext_s;
    // One guard bit is enough: a disagreement with the sign bit means overflow.
    if (sum_s[ACC_WIDTH] != sum_s[ACC_WIDTH-1]) begin
      sat_s = sum_s[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
    end else begin
      sat_s = sum_s[ACC_WIDTH-1:0];
    end
    if (in_valid && (cnt_r == CNT_LAST)) begin
      dump_s = 1'b1;
    end else begin
      dump_s = 1'b0;
    end
    scan_bit_s = scan_r[pos_r];
  end

  // Accumulator and sample counter; restart from zero on the dump edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      acc_r <= {ACC_WIDTH{1'b0}};
      cnt_r <= {CNT_W{1'b0}};
    end else if (in_valid) begin
      if (dump_s) begin
        acc_r <= {ACC_WIDTH{1'b0}};
        cnt_r <= {CNT_W{1'b0}};
      end else begin
        acc_r <= sat_s;
        cnt_r <= cnt_r + CNT_ONE;
      end
    end else begin
      acc_r <= acc_r;
      cnt_r <= cnt_r;
    end
  end

  // Scan FSM: capture a dump when idle, walk one bit per cycle, publish result.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r     <= IDLE;
      scan_r      <= {ACC_WIDTH{1'b0}};
      pos_r       <= POS_ZERO;
      out_valid_r <= 1'b0;
      out_value_r <= {ACC_WIDTH{1'b0}};
      out_index_r <= POS_ZERO;
      overrun_r   <= 1'b0;
    end else begin
      out_valid_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (dump_s) begin
            scan_r  <= sat_s;
            pos_r   <= POS_TOP;
            state_r <= SCAN;
          end
        end
        SCAN: begin
          // A dump while scanning is dropped, even on the completing edge.
          if (dump_s) begin
            overrun_r <= 1'b1;
          end
          if ((scan_bit_s != scan_r[ACC_WIDTH-1]) || (pos_r == POS_ZERO)) begin
            out_value_r <= scan_r;
            out_index_r <= (scan_bit_s != scan_r[ACC_WIDTH-1]) ? pos_r : POS_ZERO;
            out_valid_r <= 1'b1;
            state_r     <= IDLE;
          end else begin
            pos_r <= pos_r - POS_ONE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign out_valid = out_valid_r;
  assign out_value = out_value_r;
  assign out_index = out_index_r;
  assign overrun   = overrun_r;

endmodule

// File: tb/tb_fll_accum_index.sv
// Self-checking bench for fll_accum_index: directed test-plan steps followed by
// randomized traffic, all compared cycle by cycle against a behavioural model
// built from integer arithmetic and a predicted completion time per dump.
module tb_fll_accum_index;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [15:0] in_sample;
  logic        out_valid;
  logic [18:0] out_value;
  logic [4:0]  out_index;
  logic        overrun;

  logic        in_valid16;
  logic [15:0] in_sample16;
  logic        out_valid16;
  logic [18:0] out_value16;
  logic [4:0]  out_index16;
  logic        overrun16;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int          ecount;
  int          m_acc;
  int          m_cnt;
  bit          m_pend;
  int          m_pend_edge;
  int          m_pend_val;
  int          m_pend_idx;
  logic        exp_valid;
  logic [18:0] exp_val;
  logic [4:0]  exp_idx;
  logic        exp_ovr;

  always #5 clk = ~clk;

  fll_accum_index u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_sample(in_sample),
    .out_valid(out_valid), .out_value(out_value), .out_index(out_index), .overrun(overrun)
  );

  fll_accum_index #(.DUMP_COUNT(16)) u_dut16 (
    .clk(clk), .reset(reset), .in_valid(in_valid16), .in_sample(in_sample16),
    .out_valid(out_valid16), .out_value(out_value16), .out_index(out_index16), .overrun(overrun16)
  );

  // Highest magnitude bit that differs from the sign: for negatives that is
  // the top set bit of (-v-1), for non-negatives the top set bit of v.
  function automatic int msb_index(input int v);
    int m;
    int p;
    m = (v < 0) ? (-v - 1) : v;
    p = 0;
    while (m > 1) begin
      m = m >> 1;
      p++;
    end
    return p;
  endfunction

  // Advance the model by one rising edge.
  task automatic model_edge(input logic r, input logic v, input int s);
    bit busy;
    int tot;
    ecount++;
    exp_valid = 1'b0;
    if (!r) begin
      m_acc = 0; m_cnt = 0; m_pend = 0;
      exp_val = 19'd0; exp_idx = 5'd0; exp_ovr = 1'b0;
      return;
    end
    busy = m_pend;
    if (m_pend && ecount == m_pend_edge) begin
      exp_valid = 1'b1;
      exp_val   = m_pend_val[18:0];
      exp_idx   = m_pend_idx[4:0];
      m_pend    = 0;
    end
    if (v) begin
      m_acc = m_acc + s;
      if (m_acc > 262143)  m_acc = 262143;
      if (m_acc < -262144) m_acc = -262144;
      m_cnt++;
      if (m_cnt == 8) begin
        tot   = m_acc;
        m_acc = 0;
        m_cnt = 0;
        if (busy) begin
          exp_ovr = 1'b1;
        end else begin
          m_pend      = 1;
          m_pend_val  = tot;
          m_pend_idx  = msb_index(tot);
          m_pend_edge = ecount + 1 + (17 - m_pend_idx);
        end
      end
    end
  endtask

  task automatic check_outputs();
    total++;
    assert (out_valid === exp_valid) else begin
      bad++; $error("FAIL out_valid edge=%0d got=%0b exp=%0b", ecount, out_valid, exp_valid);
    end
    total++;
    assert (out_value === exp_val) else begin
      bad++; $error("FAIL out_value edge=%0d got=%0h exp=%0h", ecount, out_value, exp_val);
    end
    total++;
    assert (out_index === exp_idx) else begin
      bad++; $error("FAIL out_index edge=%0d got=%0d exp=%0d", ecount, out_index, exp_idx);
    end
    total++;
    assert (overrun === exp_ovr) else begin
      bad++; $error("FAIL overrun edge=%0d got=%0b exp=%0b", ecount, overrun, exp_ovr);
    end
  endtask

  task automatic step(input logic r, input logic v, input logic [15:0] s);
    reset     = r;
    in_valid  = v;
    in_sample = s;
    @(posedge clk);
    model_edge(r, v, int'($signed(s)));
    #1;
    check_outputs();
  endtask

  task automatic feed(input int n, input logic [15:0] s);
    for (int i = 0; i < n; i++) step(1'b1, 1'b1, s);
  endtask

  // Idle until the next result (bounded) and compare with hand-derived values.
  task automatic wait_result(input string tag, input logic [18:0] ev, input logic [4:0] ei);
    bit seen;
    seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      step(1'b1, 1'b0, 16'd0);
      seen = (out_valid === 1'b1);
    end
    total++;
    assert (seen) else begin
      bad++; $error("FAIL %s_timeout got=no_pulse exp=pulse", tag);
    end
    total++;
    assert (out_value === ev) else begin
      bad++; $error("FAIL %s_value got=%0h exp=%0h", tag, out_value, ev);
    end
    total++;
    assert (out_index === ei) else begin
      bad++; $error("FAIL %s_index got=%0d exp=%0d", tag, out_index, ei);
    end
  endtask

  task automatic run16(input string tag, input logic [15:0] s, input logic [18:0] ev);
    bit seen;
    seen = 0;
    in_valid16  = 1'b1;
    in_sample16 = s;
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 16'd0);
    in_valid16 = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      step(1'b1, 1'b0, 16'd0);
      seen = (out_valid16 === 1'b1);
    end
    total++;
    assert (seen) else begin
      bad++; $error("FAIL %s_timeout got=no_pulse exp=pulse", tag);
    end
    total++;
    assert (out_value16 === ev) else begin
      bad++; $error("FAIL %s_value got=%0h exp=%0h", tag, out_value16, ev);
    end
    total++;
    assert (out_index16 === 5'd17) else begin
      bad++; $error("FAIL %s_index got=%0d exp=17", tag, out_index16);
    end
  endtask

  initial begin
    logic [15:0] rs;
    ecount = 0; m_acc = 0; m_cnt = 0; m_pend = 0;
    m_pend_edge = 0; m_pend_val = 0; m_pend_idx = 0;
    exp_valid = 1'b0; exp_val = 19'd0; exp_idx = 5'd0; exp_ovr = 1'b0;
    in_valid16 = 1'b0; in_sample16 = 16'd0;

    // Reset state
    step(1'b0, 1'b0, 16'd0);
    step(1'b0, 1'b1, 16'h1234);

    // Directed test-plan cases
    feed(8, 16'd1000);
    wait_result("pos1000", 19'd8000, 5'd12);
    feed(8, 16'h7FFF);
    wait_result("posmax", 19'd262136, 5'd17);
    feed(8, 16'hFFFF);
    wait_result("neg1", 19'h7FFF8, 5'd2);
    feed(8, 16'h8000);
    wait_result("negmax", 19'h40000, 5'd17);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, 16'd0);
      for (int j = 0; j < 3; j++) step(1'b1, 1'b0, 16'h5555);
    end
    wait_result("zero_gaps", 19'd0, 5'd0);

    // Back-to-back dumps: second lands mid-scan and is dropped
    feed(24, 16'd8);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 16'd0);
    total++;
    assert (overrun === 1'b1) else begin
      bad++; $error("FAIL overrun_sticky got=%0b exp=1", overrun);
    end

    // Reset in the middle of a scan
    feed(8, 16'd0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 16'd0);
    step(1'b0, 1'b0, 16'd0);
    for (int i = 0; i < 25; i++) step(1'b1, 1'b0, 16'd0);
    total++;
    assert (overrun === 1'b0 && out_value === 19'd0) else begin
      bad++; $error("FAIL abort_scan got=ovr%0b/val%0h exp=ovr0/val0", overrun, out_value);
    end
    feed(8, 16'd1000);
    wait_result("after_abort", 19'd8000, 5'd12);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 4))
        0:       rs = 16'h7FFF;
        1:       rs = 16'h8000;
        2:       rs = 16'($urandom_range(0, 63)) - 16'd32;
        default: rs = 16'($urandom);
      endcase
      step(($urandom_range(0, 249) == 0) ? 1'b0 : 1'b1,
           ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0, rs);
    end

    // Saturation with a 16-sample interval
    step(1'b0, 1'b0, 16'd0);
    run16("sat16_pos", 16'h7FFF, 19'd262143);
    run16("sat16_neg", 16'h8000, 19'h40000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
